// File: rtl/wbh_clkctl_pkg.sv
// Shared definitions for the wb_host clock/control register bank.
// Holds the channel FSM state type, the CH_CTRL field layout and the
// address helpers for the two read-only registers that follow the channel
// registers.
package wbh_clkctl_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } chan_st_e;

  // CH_CTRL layout: divider in the low bits, enable at bit 16.
  localparam int EN_BIT = 16;

  // STATUS sits right after the last channel register, ACTIVE_EN after it.
  function automatic int status_addr(input int nch);
    return nch;
  endfunction

  function automatic int active_en_addr(input int nch);
    return nch + 1;
  endfunction

endpackage

// File: rtl/wbh_clk_chan.sv
// One clock-enable channel: shadow register, reconfiguration FSM, divider
// and drain counter.
// Ports:
//   mclk, reset_n      clock, asynchronous active-low reset
//   wr                 one-cycle write strobe for this channel's CH_CTRL
//   wr_div/wr_div_mask divider write data and per-bit byte-enable mask
//   wr_en_val/_mask    enable write data and its byte-enable
//   shadow_div/_en     programmed (shadow) configuration, for readback
//   active_en          enable currently in effect
//   pending            a write is waiting to be applied
//   state              FSM state (debug visibility)
//   gate               clock-gate enable, high only in RUN
//   div_en             divided clock-enable pulse
module wbh_clk_chan
  import wbh_clkctl_pkg::*;
#(
  parameter int               DIV_W     = 8,
  parameter int               GATE_WAIT = 4,
  parameter logic [DIV_W-1:0] RST_DIV   = '0,
  parameter logic             RST_EN    = 1'b1
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_div_mask,
  input  logic             wr_en_val,
  input  logic             wr_en_mask,
  output logic [DIV_W-1:0] shadow_div,
  output logic             shadow_en,
  output logic             active_en,
  output logic             pending,
  output chan_st_e         state,
  output logic             gate,
  output logic             div_en
);

  localparam int WC_W = (GATE_WAIT > 1) ? $clog2(GATE_WAIT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(GATE_WAIT - 1);

  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [WC_W-1:0]  wait_cnt;

  // cnt holds the position within the current period; it restarts at the
  // terminal value so it never runs past active_div.
  assign cnt_nxt = (cnt == active_div) ? '0 : cnt + 1'b1;

  // div_en is registered: it is computed for the cycle being entered, so
  // a write landing on this edge already suppresses the next pulse.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_div <= RST_DIV;
      shadow_en  <= RST_EN;
      active_div <= RST_DIV;
      active_en  <= RST_EN;
      pending    <= 1'b0;
      cnt        <= '0;
      wait_cnt   <= '0;
      state      <= RST_EN ? RUN : OFF;
      gate       <= RST_EN;
      div_en     <= 1'b0;
    end else begin
      div_en <= 1'b0;
      case (state)
        OFF: begin
          cnt  <= '0;
          gate <= 1'b0;
          if (pending) begin
            pending <= 1'b0;
            if (shadow_en) state <= LOAD;
          end
        end
        LOAD: begin
          active_div <= shadow_div;
          active_en  <= shadow_en;
          cnt        <= '0;
          pending    <= 1'b0;
          if (shadow_en) begin
            state  <= RUN;
            gate   <= 1'b1;
            div_en <= (shadow_div == '0) && !wr;
          end else begin
            state <= OFF;
            gate  <= 1'b0;
          end
        end
        RUN: begin
          if (pending) begin
            state    <= DRAIN;
            gate     <= 1'b0;
            cnt      <= '0;
            wait_cnt <= '0;
          end else begin
            cnt    <= cnt_nxt;
            div_en <= (cnt_nxt == active_div) && !wr;
          end
        end
        DRAIN: begin
          gate <= 1'b0;
          if (wait_cnt == WAIT_LAST) state <= LOAD;
          else wait_cnt <= wait_cnt + 1'b1;
        end
      endcase
      // A write always re-arms pending, overriding any clear above.
      if (wr) begin
        shadow_div <= (shadow_div & ~wr_div_mask) | (wr_div & wr_div_mask);
        if (wr_en_mask) shadow_en <= wr_en_val;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbh_clkctl_reg.sv
// Clock/control register bank: NCH independent clock-enable channels with
// programmable integer dividers and glitch-free reconfiguration.
// Ports:
//   mclk, reset_n        clock, asynchronous active-low reset
//   reg_cs/wr/addr/      reg bus request (select, direction, word address,
//   wdata/be             write data, byte enables)
//   reg_rdata, reg_ack   registered read data, single-cycle acknowledge
//   clk_div_en           per-channel divided clock-enable pulse
//   clk_gate_en          per-channel clock-gate enable
//   cfg_busy             per-channel reconfiguration in progress
module wbh_clkctl_reg
  import wbh_clkctl_pkg::*;
#(
  parameter int               NCH       = 4,
  parameter int               DIV_W     = 8,
  parameter int               GATE_WAIT = 4,
  parameter int               AW        = 4,
  parameter logic [DIV_W-1:0] RST_DIV   = '0,
  parameter logic [NCH-1:0]   RST_EN    = '1
) (
  input  logic           mclk,
  input  logic           reset_n,
  input  logic           reg_cs,
  input  logic           reg_wr,
  input  logic [AW-1:0]  reg_addr,
  input  logic [31:0]    reg_wdata,
  input  logic [3:0]     reg_be,
  output logic [31:0]    reg_rdata,
  output logic           reg_ack,
  output logic [NCH-1:0] clk_div_en,
  output logic [NCH-1:0] clk_gate_en,
  output logic [NCH-1:0] cfg_busy
);

  localparam logic [AW-1:0] STATUS_A = AW'(status_addr(NCH));
  localparam logic [AW-1:0] ACTEN_A  = AW'(active_en_addr(NCH));

  // Bus handshake: reg_cs is a request held by the host; the block accepts
  // it on the first edge where reg_ack is low, committing a write or
  // capturing read data on that edge and raising reg_ack for exactly one
  // cycle. The request seen while reg_ack is high is not accepted again,
  // so every access takes two cycles.
  logic access;
  logic wr_stb;
  assign access = reg_cs && !reg_ack;
  assign wr_stb = access && reg_wr;

  // Byte enable b/8 governs divider bit b.
  logic [DIV_W-1:0] div_mask;
  for (genvar b = 0; b < DIV_W; b++) begin : g_mask
    assign div_mask[b] = reg_be[b/8];
  end

  logic [DIV_W-1:0] sh_div [NCH];
  logic [NCH-1:0]   sh_en;
  logic [NCH-1:0]   act_en;
  logic [NCH-1:0]   pend;
  chan_st_e         ch_state [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    wbh_clk_chan #(
      .DIV_W    (DIV_W),
      .GATE_WAIT(GATE_WAIT),
      .RST_DIV  (RST_DIV),
      .RST_EN   (RST_EN[g])
    ) u_chan (
      .mclk       (mclk),
      .reset_n    (reset_n),
      .wr         (wr_stb && (reg_addr == AW'(g))),
      .wr_div     (reg_wdata[DIV_W-1:0]),
      .wr_div_mask(div_mask),
      .wr_en_val  (reg_wdata[EN_BIT]),
      .wr_en_mask (reg_be[2]),
      .shadow_div (sh_div[g]),
      .shadow_en  (sh_en[g]),
      .active_en  (act_en[g]),
      .pending    (pend[g]),
      .state      (ch_state[g]),
      .gate       (clk_gate_en[g]),
      .div_en     (clk_div_en[g])
    );
    assign cfg_busy[g] = pend[g] | (ch_state[g] == LOAD) | (ch_state[g] == DRAIN);
  end

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCH; i++) begin
      if (reg_addr == AW'(i)) begin
        rd_mux[DIV_W-1:0] = sh_div[i];
        rd_mux[EN_BIT]    = sh_en[i];
      end
    end
    if (reg_addr == STATUS_A) rd_mux = 32'(cfg_busy);
    if (reg_addr == ACTEN_A)  rd_mux = 32'(act_en);
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      reg_ack <= access;
      if (access && !reg_wr) reg_rdata <= rd_mux;
    end
  end

  // Upper write-data bits and unused byte enables carry no register state.
  logic unused_bus;
  assign unused_bus = ^{reg_wdata, reg_be};

endmodule

// File: tb/tb_wbh_clkctl_reg.sv
// Bench for wbh_clkctl_reg with default parameters.
module tb_wbh_clkctl_reg;

  localparam int NCH       = 4;
  localparam int DIV_W     = 8;
  localparam int GATE_WAIT = 4;
  localparam int AW        = 4;

  localparam int P_OFF   = 0;
  localparam int P_LOAD  = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;

  // ---------------- clock / reset / DUT ----------------
  logic           mclk = 1'b0;
  logic           reset_n;
  logic           reg_cs;
  logic           reg_wr;
  logic [AW-1:0]  reg_addr;
  logic [31:0]    reg_wdata;
  logic [3:0]     reg_be;
  logic [31:0]    reg_rdata;
  logic           reg_ack;
  logic [NCH-1:0] clk_div_en;
  logic [NCH-1:0] clk_gate_en;
  logic [NCH-1:0] cfg_busy;

  always #5 mclk = ~mclk;

  wbh_clkctl_reg dut (
    .mclk       (mclk),
    .reset_n    (reset_n),
    .reg_cs     (reg_cs),
    .reg_wr     (reg_wr),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_be     (reg_be),
    .reg_rdata  (reg_rdata),
    .reg_ack    (reg_ack),
    .clk_div_en (clk_div_en),
    .clk_gate_en(clk_gate_en),
    .cfg_busy   (cfg_busy)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is described by its phase, how many RUN cycles it has
  // spent since the last load (pulse when that count is a multiple of
  // div+1) and how many drain cycles remain.
  int          ph        [NCH];
  bit          pend      [NCH];
  bit          sh_en     [NCH];
  logic [7:0]  sh_div    [NCH];
  bit          a_en      [NCH];
  int          a_div     [NCH];
  int          run_k     [NCH];
  int          drain_left[NCH];
  bit          first_cyc;
  bit          m_ack;

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    logic [31:0] v;
    int ai;
    v  = '0;
    ai = int'(a);
    if (ai < NCH) begin
      v[7:0] = sh_div[ai];
      v[16]  = sh_en[ai];
    end else if (ai == NCH) begin
      for (int i = 0; i < NCH; i++) v[i] = pend[i] || ph[i] == P_LOAD || ph[i] == P_DRAIN;
    end else if (ai == NCH + 1) begin
      for (int i = 0; i < NCH; i++) v[i] = a_en[i];
    end
    return v;
  endfunction

  always @(posedge mclk or negedge reset_n) begin : model
    bit acc;
    int ai;
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        ph[i] = P_RUN; pend[i] = 0; sh_en[i] = 1; sh_div[i] = 8'h00;
        a_en[i] = 1; a_div[i] = 0; run_k[i] = 1; drain_left[i] = 0;
      end
      first_cyc = 1;
      m_ack     = 0;
      exp_q.delete();
    end else begin
      acc = reg_cs && !m_ack;
      ai  = int'(reg_addr);
      if (acc && !reg_wr) exp_q.push_back(model_read(reg_addr));
      for (int i = 0; i < NCH; i++) begin
        case (ph[i])
          P_OFF: if (pend[i]) begin
            pend[i] = 0;
            if (sh_en[i]) ph[i] = P_LOAD;
          end
          P_LOAD: begin
            a_en[i]  = sh_en[i];
            a_div[i] = int'(sh_div[i]);
            pend[i]  = 0;
            if (sh_en[i]) begin ph[i] = P_RUN; run_k[i] = 1; end
            else ph[i] = P_OFF;
          end
          P_RUN: if (pend[i]) begin
            ph[i] = P_DRAIN; drain_left[i] = GATE_WAIT;
          end else run_k[i]++;
          default: begin
            drain_left[i]--;
            if (drain_left[i] == 0) ph[i] = P_LOAD;
          end
        endcase
      end
      if (acc && reg_wr && ai < NCH) begin
        if (reg_be[0]) sh_div[ai] = reg_wdata[7:0];
        if (reg_be[2]) sh_en[ai]  = reg_wdata[16];
        pend[ai] = 1;
      end
      m_ack     = acc;
      first_cyc = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge mclk) begin : cmp
    logic [NCH-1:0] eg, ed, eb;
    for (int i = 0; i < NCH; i++) begin
      eg[i] = (ph[i] == P_RUN);
      eb[i] = pend[i] || ph[i] == P_LOAD || ph[i] == P_DRAIN;
      ed[i] = (ph[i] == P_RUN) && !pend[i] && !first_cyc && (run_k[i] % (a_div[i] + 1) == 0);
    end
    check("clk_gate_en", 32'(clk_gate_en), 32'(eg));
    check("clk_div_en",  32'(clk_div_en),  32'(ed));
    check("cfg_busy",    32'(cfg_busy),    32'(eb));
    check("reg_ack",     32'(reg_ack),     32'(m_ack));
    if (m_ack && exp_q.size() > 0) check("reg_rdata", reg_rdata, exp_q.pop_front());
  end

  // ---------------- driver tasks (call at a negedge) ----------------
  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d; reg_be = b;
    @(negedge mclk);
    reg_cs = 1'b0; reg_wr = 1'b0;
    @(negedge mclk);
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
    reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = a; reg_be = 4'h0;
    @(negedge mclk);
    d = reg_rdata;
    reg_cs = 1'b0;
    @(negedge mclk);
  endtask

  // Count consecutive gate-low cycles of channel c, bounded.
  task automatic gate_low_run(input int c, output int low);
    low = 0;
    for (int k = 0; k < 40; k++) begin
      if (!clk_gate_en[c]) low++;
      else if (low > 0) break;
      @(negedge mclk);
    end
  endtask

  task automatic wait_gate_high(input int c);
    for (int k = 0; k < 40; k++) begin
      if (clk_gate_en[c]) break;
      @(negedge mclk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] rd;
    int low, pulses;
    reg_cs = 0; reg_wr = 0; reg_addr = '0; reg_wdata = '0; reg_be = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge mclk);
    check("rst_gate", 32'(clk_gate_en), 32'hF);
    check("rst_div_en", 32'(clk_div_en), 32'h0);
    check("rst_busy", 32'(cfg_busy), 32'h0);
    check("rst_rdata", reg_rdata, 32'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge mclk);
    check("default_div_en_held", 32'(clk_div_en), 32'hF);
    bus_read(AW'(0), rd);
    check("rd_ch0_reset", rd, 32'h0001_0000);

    // ch0 divide by 4
    bus_write(AW'(0), 32'h0001_0003, 4'b0111);
    gate_low_run(0, low);
    check("ch0_gate_low_cycles", 32'(low), 32'(GATE_WAIT + 1));
    pulses = 0;
    repeat (16) begin @(negedge mclk); if (clk_div_en[0]) pulses++; end
    check("ch0_pulses_in_16", 32'(pulses), 32'd4);

    // ch1 disable, then re-enable with div 0
    bus_write(AW'(1), 32'h0000_0000, 4'b0100);
    repeat (10) @(negedge mclk);
    check("ch1_gate_off", 32'(clk_gate_en[1]), 32'h0);
    bus_read(AW'(NCH + 1), rd);
    check("active_en_ch1_off", rd, 32'h0000_000D);
    bus_write(AW'(1), 32'h0001_0000, 4'b0111);
    repeat (10) @(negedge mclk);
    pulses = 0;
    repeat (5) begin @(negedge mclk); if (clk_div_en[1]) pulses++; end
    check("ch1_div0_held", 32'(pulses), 32'd5);

    // ch2 rewritten mid-drain: one drain, newest value loaded
    bus_write(AW'(2), 32'h0001_0005, 4'b0111);
    @(negedge mclk);
    bus_write(AW'(2), 32'h0001_0007, 4'b0111);
    wait_gate_high(2);
    low = 0; pulses = 0;
    repeat (32) begin
      @(negedge mclk);
      if (!clk_gate_en[2]) low++;
      if (clk_div_en[2]) pulses++;
    end
    check("ch2_single_drain", 32'(low), 32'd0);
    check("ch2_pulses_in_32", 32'(pulses), 32'd4);
    bus_read(AW'(2), rd);
    check("rd_ch2", rd, 32'h0001_0007);

    // byte-enable masking
    bus_write(AW'(3), 32'hFFFF_FF05, 4'b0001);
    bus_read(AW'(3), rd);
    check("rd_ch3_be0", rd, 32'h0001_0005);

    // write landing on the LOAD cycle
    bus_write(AW'(0), 32'h0001_0002, 4'b0111);
    repeat (4) @(negedge mclk);
    bus_write(AW'(0), 32'h0001_0001, 4'b0111);
    repeat (30) @(negedge mclk);
    bus_read(AW'(0), rd);
    check("rd_ch0_after_collision", rd, 32'h0001_0001);

    // async reset mid-drain
    bus_write(AW'(0), 32'h0001_0004, 4'b0111);
    @(posedge mclk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_gate", 32'(clk_gate_en), 32'hF);
    check("async_rst_div_en", 32'(clk_div_en), 32'h0);
    check("async_rst_busy", 32'(cfg_busy), 32'h0);
    check("async_rst_ack", 32'(reg_ack), 32'h0);
    @(negedge mclk);
    reset_n = 1'b1;
    repeat (2) @(negedge mclk);
    bus_read(AW'(NCH + 2), rd);
    check("rd_unmapped", rd, 32'h0);
    bus_read(AW'(0), rd);
    check("rd_ch0_after_rst", rd, 32'h0001_0000);

    // randomized traffic, checked every cycle against the model
    repeat (300) begin
      logic [AW-1:0] a;
      logic [31:0]   d;
      repeat ($urandom_range(0, 5)) @(negedge mclk);
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, NCH + 1));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        d[7:0] = 8'($urandom_range(0, 6));
        bus_write(a, d, 4'($urandom_range(0, 15)));
      end else begin
        bus_read(a, rd);
      end
    end
    repeat (40) @(negedge mclk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
